instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle control sequencer for the 8-bit single-cycle datapath (8×8 register file, operand/complement muxes, immediate mux, ALU). Fetches 32-bit instructions `{opcode[31:24], dest[23:16], src2[15:8], src1[7:0]}` from instruction memory over a request/valid handshake. Decodes each instruction and drives the datapath control signals through a fixed FETCH→DECODE→EXEC→WB sequence. Also maintains the program counter, the retired-instruction count, and the halt and error status.

## Interface
**Parameters**
- `PC_W`, default 8: program counter and `imem_addr` width.
- `CNT_W`, default 16: retired-instruction counter width.

**Ports**
- `clk` in 1: single clock; all state updates on posedge.
- `RESET` in 1: reset, asynchronous and active-low.
- `start` in 1: begin execution at PC 0; sampled only in IDLE.
- `imem_req` out 1: fetch request; high throughout FETCH.
- `imem_addr` out PC_W: current PC.
- `imem_valid` in 1: instruction word present; sampled only in FETCH.
- `imem_instr` in 32: instruction word.
- `OUT1addr`, `OUT2addr`, `INaddr` out 3: register file read/write addresses.
- `select` out 3: ALU op; equals `opcode[2:0]`.
- `out1mux`, `out2mux` out 1: 1 = register value, 0 = two's complement.
- `immediatemux` out 1: 1 = immediate to ALU operand.
- `immediate` out 8: `src1` field.
- `reg_we` out 1: register write enable; high only in WB for a legal writing instruction.
- `busy` out 1: high in FETCH/DECODE/EXEC/WB.
- `halted` out 1: high in HALT.
- `err` out 1: sticky illegal-instruction flag.
- `retired` out CNT_W: count of instructions that completed WB with a write.

## Operation
**States:** IDLE, FETCH, DECODE, EXEC, WB, HALT.

**State transitions**
- IDLE: `start=1` → FETCH.
- FETCH: `imem_valid=1` → latch `imem_instr` into the instruction register (IR), go to DECODE. Otherwise stay in FETCH with `imem_req` held high.
- DECODE: register `INaddr=dest[2:0]`, `OUT2addr=src2[2:0]`, `OUT1addr=src1[2:0]`, `select`, all mux controls and `immediate`. These outputs stay stable through EXEC and WB. → EXEC.
- EXEC: wait one cycle for the ALU/register read path. → WB.
- WB:
  - If legal: assert `reg_we`, increment `retired`, set PC = PC+1 (wraps modulo 2^PC_W).
  - If illegal: no write, set `err`, PC+1.
  - Then → FETCH.
- HALT: outputs frozen and `reg_we=0`. Only `RESET` exits HALT; `start` is ignored.

**Opcode decode** (values are out1mux, out2mux, immediatemux, select)
- 0x08 loadi: 0, 0, 1, 000.
- 0x00 mov: 1, 0, 0, 000.
- 0x01 add: 1, 1, 0, 001.
- 0x09 sub: 1, 0, 0, 001. Operand 2 is complemented and `select` is forced to 001.
- 0x02 and: 1, 1, 0, 010.
- 0x03 or: 1, 1, 0, 011.
- 0xFF halt: no write; go to HALT from DECODE without passing through EXEC/WB; PC unchanged; `retired` unchanged.

**Illegal instructions**
- An instruction is illegal if the opcode is not listed above, `dest[7:3]≠0`, or a source field that the opcode reads has `[7:3]≠0`.
- loadi does not check `src1`, because it is the immediate.
- An illegal instruction still passes through EXEC and WB (with no write).

**Counter and error flag**
- `retired` saturates at all-ones.
- `err` stays set until reset.

## Timing
**Reset values** (asynchronous, `RESET=0`): state IDLE; PC, IR, `retired`, and all address, select and immediate outputs 0; `imem_req`, `reg_we`, `busy`, `halted`, `err`, all muxes 0.

**Latency**
- 4 cycles per instruction with zero-wait memory (`imem_valid` high on the first FETCH cycle).
- Each wait cycle in FETCH adds 1 cycle.
- Halt: FETCH + DECODE = 2 cycles, then HALT.

**Write pulse:** `reg_we` is high for exactly one full clock period. That period covers the register file's negedge write.

**Boundary conditions**
- `imem_valid` outside FETCH: ignored.
- `start` while busy: ignored.
- `start` and `imem_valid` asserted together in IDLE: only `start` acts.
- `RESET` asserted mid-instruction: aborts immediately; no `reg_we` pulse is produced; PC returns to 0.
- PC = 2^PC_W−1 completing WB: wraps to 0 and execution continues.

## Structure
**Shared package `seq_pkg`**
- Opcode constants: `OP_MOV`, `OP_ADD`, `OP_AND`, `OP_OR`, `OP_LOADI`, `OP_SUB`, `OP_HALT`.
- State enum.
- Instruction field bit positions.

**Sub-module `instr_decoder`:** combinational. Maps IR to address fields, `select`, mux controls and the `legal` flag. The FSM, PC, IR and counters live in `instr_sequencer`.

## Test plan
- **loadi:** reset, then `start`; memory returns 0x08_03_00_2A with zero wait. → DECODE sets `INaddr=3`, `immediate=0x2A`, `immediatemux=1`. `reg_we` is high in cycle 4 only. `retired=1`, `imem_addr=1`.
- **Mixed program:** program is add 0x01_05_01_02, sub 0x09_06_04_03, halt 0xFF. → add drives `select=001` with both muxes 1; sub drives `out2mux=0`, `select=001`; then `halted=1`, `busy=0`, `retired=2`, PC=2.
- **Fetch wait states:** `imem_valid` held low for 3 FETCH cycles. → `imem_req` stays high for 4 cycles and the instruction takes 7 cycles total.
- **Illegal instructions:** 0x05_01_02_03, then 0x01_09_00_00. → no `reg_we` for either; `err=1` after the first and stays set; PC advances to 2; `retired=0`.
- **Reset during EXEC:** assert `RESET=0` in EXEC of an add. → all outputs at their reset values immediately; no write pulse; restarting with `start` fetches address 0.
- **PC wrap:** run with PC_W=2 for 5 legal mov instructions. → `imem_addr` sequence is 0,1,2,3,0; `retired=5`.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared opcodes, FSM states and instruction field layout for the instruction sequencer.
package seq_pkg;

    localparam logic [7:0] OP_MOV   = 8'h00;
    localparam logic [7:0] OP_ADD   = 8'h01;
    localparam logic [7:0] OP_AND   = 8'h02;
    localparam logic [7:0] OP_OR    = 8'h03;
    localparam logic [7:0] OP_LOADI = 8'h08;
    localparam logic [7:0] OP_SUB   = 8'h09;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    // Instruction word: {opcode, dest, src2, src1}
    localparam int unsigned FIELD_W  = 8;
    localparam int unsigned OPC_LSB  = 24;
    localparam int unsigned DST_LSB  = 16;
    localparam int unsigned SRC2_LSB = 8;
    localparam int unsigned SRC1_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [2:0] out1addr;
        logic [2:0] out2addr;
        logic [2:0] inaddr;
        logic [2:0] select;
        logic       out1mux;
        logic       out2mux;
        logic       immmux;
        logic [7:0] imm;
        logic       legal;
        logic       halt;
    } decode_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-memory request/valid handshake between the sequencer and its memory.
interface instr_sequencer_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [31:0]     imem_instr;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_instr);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_instr);
endinterface

// File: rtl/instr_sequencer_decoder.sv
// Combinational instruction decode: register addresses, ALU controls and legality.
module instr_decoder
    import seq_pkg::*;
(
    input  logic [31:0] i_ir,
    output decode_t     o_dec
);
    logic [7:0] w_op;
    logic [7:0] w_dst;
    logic [7:0] w_src2;
    logic [7:0] w_src1;
    logic       w_known;
    logic       w_rd1;
    logic       w_rd2;

    assign w_op   = i_ir[OPC_LSB  +: FIELD_W];
    assign w_dst  = i_ir[DST_LSB  +: FIELD_W];
    assign w_src2 = i_ir[SRC2_LSB +: FIELD_W];
    assign w_src1 = i_ir[SRC1_LSB +: FIELD_W];

    always_comb begin
        o_dec          = '0;
        w_known        = 1'b1;
        w_rd1          = 1'b0;
        w_rd2          = 1'b0;
        o_dec.inaddr   = w_dst[2:0];
        o_dec.out2addr = w_src2[2:0];
        o_dec.out1addr = w_src1[2:0];
        o_dec.select   = w_op[2:0];
        o_dec.imm      = w_src1;
        case (w_op)
            OP_LOADI: o_dec.immmux = 1'b1;
            OP_MOV: begin
                o_dec.out1mux = 1'b1;
                w_rd1         = 1'b1;
            end
            OP_ADD, OP_AND, OP_OR: begin
                o_dec.out1mux = 1'b1;
                o_dec.out2mux = 1'b1;
                w_rd1         = 1'b1;
                w_rd2         = 1'b1;
            end
            // Subtract is add with operand 2 fed through the complement path
            OP_SUB: begin
                o_dec.out1mux = 1'b1;
                w_rd1         = 1'b1;
                w_rd2         = 1'b1;
            end
            OP_HALT: begin
                o_dec.halt = 1'b1;
                w_known    = 1'b0;
            end
            default: w_known = 1'b0;
        endcase
        o_dec.legal = w_known && (w_dst[7:3] == '0)
                      && !(w_rd1 && (w_src1[7:3] != '0))
                      && !(w_rd2 && (w_src2[7:3] != '0));
    end
endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer: PC, IR, retired count and halt/error status.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              start,
    instr_sequencer_if.master imem,
    output logic [2:0]        OUT1addr,
    output logic [2:0]        OUT2addr,
    output logic [2:0]        INaddr,
    output logic [2:0]        select,
    output logic              out1mux,
    output logic              out2mux,
    output logic              immediatemux,
    output logic [7:0]        immediate,
    output logic              reg_we,
    output logic              busy,
    output logic              halted,
    output logic              err,
    output logic [CNT_W-1:0]  retired
);
    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic [31:0]      r_ir;
    logic [CNT_W-1:0] r_retired;
    logic             r_req;
    logic             r_we;
    logic             r_busy;
    logic             r_halted;
    logic             r_err;
    decode_t          r_ctl;
    decode_t          w_dec;

    instr_decoder u_dec (
        .i_ir  (r_ir),
        .o_dec (w_dec)
    );

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_ir      <= '0;
            r_retired <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_busy    <= 1'b0;
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_ctl     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_FETCH;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (imem.imem_valid) begin
                        r_ir    <= imem.imem_instr;
                        r_req   <= 1'b0;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_ctl <= w_dec;
                    if (w_dec.halt) begin
                        r_state  <= S_HALT;
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                // reg_we is registered here so it spans exactly the WB cycle
                S_EXEC: begin
                    r_we    <= w_dec.legal;
                    r_state <= S_WB;
                end
                S_WB: begin
                    r_we    <= 1'b0;
                    r_pc    <= r_pc + 1'b1;
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                    if (w_dec.legal) begin
                        if (r_retired != '1) r_retired <= r_retired + 1'b1;
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign OUT1addr       = r_ctl.out1addr;
    assign OUT2addr       = r_ctl.out2addr;
    assign INaddr         = r_ctl.inaddr;
    assign select         = r_ctl.select;
    assign out1mux        = r_ctl.out1mux;
    assign out2mux        = r_ctl.out2mux;
    assign immediatemux   = r_ctl.immmux;
    assign immediate      = r_ctl.imm;
    assign reg_we         = r_we;
    assign busy           = r_busy;
    assign halted         = r_halted;
    assign err            = r_err;
    assign retired        = r_retired;
endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench: memory model pushes expected per-instruction results, monitor checks at completion.
module tb_instr_sequencer;
    localparam logic [31:0] HALTW = 32'hFF00_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic RESET, start, w_start;

    instr_sequencer_if #(.PC_W(8)) imem_bus ();
    instr_sequencer_if #(.PC_W(2)) wrap_bus ();

    logic [2:0]  OUT1addr, OUT2addr, INaddr, select;
    logic        out1mux, out2mux, immediatemux, reg_we, busy, halted, err;
    logic [7:0]  immediate;
    logic [15:0] retired;

    logic [2:0]  w_o1, w_o2, w_in, w_sel;
    logic        w_m1, w_m2, w_mi, w_we, w_busy, w_halted, w_err;
    logic [7:0]  w_imm;
    logic [2:0]  w_retired;

    instr_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .RESET(RESET), .start(start), .imem(imem_bus),
        .OUT1addr(OUT1addr), .OUT2addr(OUT2addr), .INaddr(INaddr), .select(select),
        .out1mux(out1mux), .out2mux(out2mux), .immediatemux(immediatemux),
        .immediate(immediate), .reg_we(reg_we), .busy(busy), .halted(halted),
        .err(err), .retired(retired)
    );

    instr_sequencer #(.PC_W(2), .CNT_W(3)) u_wrap (
        .clk(clk), .RESET(RESET), .start(w_start), .imem(wrap_bus),
        .OUT1addr(w_o1), .OUT2addr(w_o2), .INaddr(w_in), .select(w_sel),
        .out1mux(w_m1), .out2mux(w_m2), .immediatemux(w_mi),
        .immediate(w_imm), .reg_we(w_we), .busy(w_busy), .halted(w_halted),
        .err(w_err), .retired(w_retired)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: legality and mux controls from the opcode table
    function automatic void ref_decode(input logic [31:0] w, output bit halt, output bit legal,
                                       output logic [2:0] muxes);
        int op, d, s1, s2;
        bit known, r1, r2;
        op = w[31:24]; d = w[23:16]; s2 = w[15:8]; s1 = w[7:0];
        known = 1; r1 = 0; r2 = 0; muxes = 3'b000;
        case (op)
            8:        muxes = 3'b001;
            0:        begin r1 = 1; muxes = 3'b100; end
            1, 2, 3:  begin r1 = 1; r2 = 1; muxes = 3'b110; end
            9:        begin r1 = 1; r2 = 1; muxes = 3'b100; end
            default:  known = 0;
        endcase
        halt  = (op == 255);
        legal = !halt && known && d < 8 && (!r1 || s1 < 8) && (!r2 || s2 < 8);
    endfunction

    function automatic logic [7:0] rand_field();
        if ($urandom_range(0, 9) == 0) return 8'($urandom);
        return 8'($urandom_range(0, 7));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [7:0] op, d, s1, s2;
        case ($urandom_range(0, 6))
            0: op = 8'h00;
            1: op = 8'h01;
            2: op = 8'h02;
            3: op = 8'h03;
            4: op = 8'h08;
            5: op = 8'h09;
            default: op = 8'($urandom);
        endcase
        if (op == 8'hFF) op = 8'h04;
        d  = rand_field();
        s1 = rand_field();
        s2 = (op == 8'h00) ? 8'($urandom_range(0, 7)) : rand_field();
        return {op, d, s2, s1};
    endfunction

    typedef struct {
        logic [31:0] w;
        bit          halt;
        bit          legal;
        logic [2:0]  muxes;
        int          next_pc;
        int          ret;
        bit          err;
        int          cycles;
        int          we;
    } exp_t;

    exp_t        q[$];
    logic [31:0] prog[256];
    int          m_pc, m_ret, fetch_n, fetch_limit, force_wait, waits_left, cur_waits;
    bit          m_err, mem_prev_req;

    // Instruction memory with random wait states; issues expected results into the scoreboard
    always @(posedge clk) begin
        #1;
        if (!RESET) begin
            imem_bus.imem_valid = 1'b0;
            mem_prev_req = 0;
        end else if (imem_bus.imem_req) begin
            if (!mem_prev_req) begin
                if (force_wait >= 0) waits_left = force_wait;
                else waits_left = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
                cur_waits = waits_left;
            end
            mem_prev_req = 1;
            if (waits_left > 0) begin
                waits_left--;
                imem_bus.imem_valid = 1'b0;
                imem_bus.imem_instr = $urandom;
            end else begin
                exp_t e;
                bit last;
                last = (fetch_n == fetch_limit);
                e.w = last ? HALTW : prog[m_pc];
                ref_decode(e.w, e.halt, e.legal, e.muxes);
                e.cycles = cur_waits + (e.halt ? 2 : 4);
                e.we = 0;
                if (!e.halt) begin
                    if (e.legal) begin
                        if (m_ret < 65535) m_ret++;
                        e.we = 1;
                    end else begin
                        m_err = 1;
                    end
                    m_pc = (m_pc + 1) % 256;
                end
                e.next_pc = m_pc; e.ret = m_ret; e.err = m_err;
                q.push_back(e);
                fetch_n++;
                imem_bus.imem_valid = 1'b1;
                imem_bus.imem_instr = last ? HALTW : prog[imem_bus.imem_addr];
            end
        end else begin
            mem_prev_req = 0;
            imem_bus.imem_valid = ($urandom_range(0, 3) == 0);
            imem_bus.imem_instr = $urandom;
        end
    end

    bit act, mprev_req, mprev_halt;
    int cyc = 0, start_cyc = 0, we_cnt = 0, we_total = 0;

    task automatic complete();
        exp_t e;
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("pc", imem_bus.imem_addr, e.next_pc);
            chk("retired", retired, e.ret);
            chk("err", err, e.err);
            chk("halted", halted, e.halt);
            chk("busy", busy, !e.halt);
            chk("we_pulses", we_cnt, e.we);
            chk("cycles", cyc - start_cyc, e.cycles);
            chk("select", select, (e.w >> 24) % 8);
            chk("INaddr", INaddr, (e.w >> 16) % 8);
            chk("OUT2addr", OUT2addr, (e.w >> 8) % 8);
            chk("OUT1addr", OUT1addr, e.w % 8);
            chk("immediate", immediate, e.w % 256);
            if (e.legal) chk("muxes", {out1mux, out2mux, immediatemux}, e.muxes);
        end
    endtask

    // An instruction completes when the next fetch starts or the sequencer halts
    always @(negedge clk) begin
        if (!RESET) begin
            act = 0; mprev_req = 0; mprev_halt = 0; we_cnt = 0;
        end else begin
            cyc++;
            if (reg_we) begin we_cnt++; we_total++; end
            if ((imem_bus.imem_req && !mprev_req) || (halted && !mprev_halt)) begin
                if (act) complete();
                act = imem_bus.imem_req;
                start_cyc = cyc;
                we_cnt = 0;
            end
            mprev_req = imem_bus.imem_req;
            mprev_halt = halted;
        end
    end

    bit wrap_on = 0;
    int wk = 0;

    always @(posedge clk) begin
        #1;
        wrap_bus.imem_valid = wrap_bus.imem_req;
        wrap_bus.imem_instr = 32'h0001_0002;
    end

    always @(negedge clk) begin
        if (wrap_on && RESET && wrap_bus.imem_req && wrap_bus.imem_valid) begin
            chk("wrap_addr", wrap_bus.imem_addr, wk % 4);
            wk++;
        end
    end

    task automatic do_reset();
        RESET = 1'b0;
        @(negedge clk);
        q.delete();
        m_pc = 0; m_ret = 0; m_err = 0; fetch_n = 0;
        @(negedge clk);
        RESET = 1'b1;
    endtask

    task automatic run(input int limit, input int budget, input bit noise);
        int k;
        fetch_limit = limit;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!halted && k < budget) begin
            @(negedge clk);
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            k++;
        end
        @(negedge clk);
        chk("halt_reached", halted, 1);
        chk("sb_drained", q.size(), 0);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        chk("halt_hold", halted, 1);
        chk("halt_pc", imem_bus.imem_addr, m_pc);
        chk("halt_busy", busy, 0);
        chk("halt_we", reg_we, 0);
    endtask

    initial begin
        int k, we_before;
        RESET = 1'b0; start = 1'b0; w_start = 1'b0;
        force_wait = 0; fetch_limit = 0;
        m_pc = 0; m_ret = 0; m_err = 0; fetch_n = 0;
        foreach (prog[i]) prog[i] = 32'h0;
        #12;
        chk("rst_req_busy_halt", {imem_bus.imem_req, busy, halted, err, reg_we}, 0);
        chk("rst_addr", imem_bus.imem_addr, 0);
        chk("rst_retired", retired, 0);
        chk("rst_ctl", {OUT1addr, OUT2addr, INaddr, select, immediate}, 0);
        chk("rst_mux", {out1mux, out2mux, immediatemux}, 0);
        @(negedge clk) RESET = 1'b1;

        // PC wrap with a 2-bit PC and a 3-bit saturating counter
        wk = 0; wrap_on = 1;
        @(negedge clk) w_start = 1'b1;
        @(negedge clk) w_start = 1'b0;
        k = 0;
        while (wk < 10 && k < 100) begin @(negedge clk); k++; end
        chk("wrap_fetches", wk, 10);
        chk("wrap_retired_sat", w_retired, 7);
        chk("wrap_err", w_err, 0);
        wrap_on = 0;

        do_reset();
        prog[0] = 32'h0803_002A;
        run(1, 50, 0);

        do_reset();
        prog[0] = 32'h0105_0102; prog[1] = 32'h0906_0403;
        run(2, 50, 0);

        do_reset();
        force_wait = 3;
        prog[0] = 32'h0105_0102;
        run(1, 50, 0);
        force_wait = 0;

        do_reset();
        prog[0] = 32'h0501_0203; prog[1] = 32'h0109_0000;
        run(2, 50, 0);

        // Reset asserted while an add is in EXEC
        do_reset();
        prog[0] = 32'h0105_0102;
        fetch_limit = 1;
        we_before = we_total;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        k = 0;
        while (!(imem_bus.imem_req && imem_bus.imem_valid) && k < 20) begin @(negedge clk); k++; end
        chk("exec_fetch_seen", imem_bus.imem_req && imem_bus.imem_valid, 1);
        @(posedge clk);
        @(posedge clk);
        #2 RESET = 1'b0;
        #1;
        chk("abort_flags", {imem_bus.imem_req, busy, halted, reg_we}, 0);
        chk("abort_addr", imem_bus.imem_addr, 0);
        chk("abort_ctl", {OUT1addr, OUT2addr, INaddr, select, immediate}, 0);
        chk("abort_no_we", we_total, we_before);
        do_reset();
        run(1, 50, 0);

        // Randomised program long enough to wrap the 8-bit PC
        do_reset();
        force_wait = -1;
        foreach (prog[i]) prog[i] = rand_instr();
        run(300, 5000, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
